// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the hazard controller.
// Holds the per-stage stall/flush record, the whole-pipeline hazard bundle
// (fetch->F/D, decode->D/E, execute->E/M, memory->M/W), the redirect FSM
// state enum, and a saturating increment helper for the event counters.
package hazard_ctrl_pkg;

    localparam int CNT_W = 16;
    localparam int REG_W = 5;

    typedef struct packed {
        logic stall;
        logic flush;
    } hazard_data_item_t;

    typedef struct packed {
        hazard_data_item_t fetch;
        hazard_data_item_t decode;
        hazard_data_item_t execute;
        hazard_data_item_t memory;
    } hazard_data_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } hz_state_t;

    // Increment by one, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// load_use_detect: flags a load in execute whose destination feeds a source
// operand of the instruction in decode. Register 0 is hardwired to zero and
// never creates a dependency.
// Ports: d_rs, d_rt (decode sources), e_write_reg, e_mem_to_reg (execute
// load destination), load_use (hazard flag, combinational).
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [REG_W-1:0] e_write_reg,
    input  logic             e_mem_to_reg,
    output logic             load_use
);

    assign load_use = e_mem_to_reg && (e_write_reg != '0) &&
                      ((e_write_reg == d_rs) || (e_write_reg == d_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Prioritises data-bus stall > taken branch > load-use > instruction-bus
// stall and drives per-stage stall/flush plus a PC hold. A taken branch that
// lands while an instruction fetch is outstanding enters DRAIN, where the
// wrong-path fetch is discarded until the instruction bus goes idle.
// Ports:
//   clk, reset (async, active-low)
//   d_rs, d_rt, e_write_reg, e_mem_to_reg : load-use operands
//   m_branch_taken, i_busy, d_busy         : pipeline events
//   hazard, pc_stall                       : combinational controls
//   redirect_pending                       : FSM is draining a wrong-path fetch
//   stall_cycles, flush_events             : saturating event counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [REG_W-1:0] e_write_reg,
    input  logic             e_mem_to_reg,
    input  logic             m_branch_taken,
    input  logic             i_busy,
    input  logic             d_busy,
    output hazard_data_t     hazard,
    output logic             pc_stall,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hz_state_t    state, state_next;
    hazard_data_t hz;
    logic         stall_pc;
    logic         flush_evt;
    logic         load_use;

    load_use_detect u_load_use_detect (
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .e_write_reg  (e_write_reg),
        .e_mem_to_reg (e_mem_to_reg),
        .load_use     (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= state_next;
            if (pc_stall)  stall_cycles <= sat_inc(stall_cycles);
            if (flush_evt) flush_events <= sat_inc(flush_events);
        end
    end

    always_comb begin
        hz         = '0;
        stall_pc   = 1'b0;
        flush_evt  = 1'b0;
        state_next = state;
        case (state)
            RUN: begin
                if (d_busy) begin
                    // Freeze the front of the pipe, bubble into M/W.
                    stall_pc          = 1'b1;
                    hz.fetch.stall    = 1'b1;
                    hz.decode.stall   = 1'b1;
                    hz.execute.stall  = 1'b1;
                    hz.memory.flush   = 1'b1;
                end else if (m_branch_taken) begin
                    hz.fetch.flush    = 1'b1;
                    hz.decode.flush   = 1'b1;
                    hz.execute.flush  = 1'b1;
                    flush_evt         = 1'b1;
                    // Fetch in flight is on the wrong path; hold PC and drain it.
                    if (i_busy) begin
                        stall_pc   = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (load_use) begin
                    stall_pc          = 1'b1;
                    hz.fetch.stall    = 1'b1;
                    hz.decode.flush   = 1'b1;
                end else if (i_busy) begin
                    stall_pc          = 1'b1;
                    hz.fetch.flush    = 1'b1;
                end
            end
            DRAIN: begin
                // F/D is flushed every draining cycle, so fetch never stalls here.
                stall_pc       = 1'b1;
                hz.fetch.flush = 1'b1;
                if (d_busy) begin
                    hz.decode.stall  = 1'b1;
                    hz.execute.stall = 1'b1;
                    hz.memory.flush  = 1'b1;
                end else if (m_branch_taken) begin
                    hz.decode.flush  = 1'b1;
                    hz.execute.flush = 1'b1;
                    flush_evt        = 1'b1;
                end else if (load_use) begin
                    hz.decode.flush  = 1'b1;
                end
                // A fresh redirect keeps us draining; otherwise leave once the bus is idle.
                if (!i_busy && !(m_branch_taken && !d_busy))
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Controls are forced quiet while reset is held.
    assign hazard           = reset ? hz : '0;
    assign pc_stall         = reset & stall_pc;
    assign redirect_pending = (state == DRAIN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver applies inputs each cycle,
// evaluates a reference model of the priority rules and pushes the expected
// outputs; a monitor pops one entry per cycle and compares.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   d_rs, d_rt, e_write_reg;
    logic         e_mem_to_reg, m_branch_taken, i_busy, d_busy;
    hazard_data_t hazard;
    logic         pc_stall, redirect_pending;
    logic [15:0]  stall_cycles, flush_events;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .e_write_reg(e_write_reg), .e_mem_to_reg(e_mem_to_reg),
        .m_branch_taken(m_branch_taken), .i_busy(i_busy), .d_busy(d_busy),
        .hazard(hazard), .pc_stall(pc_stall), .redirect_pending(redirect_pending),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hz;   // {f.stall,f.flush,d.stall,d.flush,e.stall,e.flush,m.stall,m.flush}
        logic        ps;
        logic        rp;
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    bit m_drain = 0;
    int m_sc    = 0;
    int m_fe    = 0;

    task automatic drive(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic mtr, input logic br,
                         input logic ib, input logic db);
        exp_t e;
        bit   lu, ev, nd;
        @(posedge clk); #1;
        reset = rn; d_rs = rs; d_rt = rt; e_write_reg = wr;
        e_mem_to_reg = mtr; m_branch_taken = br; i_busy = ib; d_busy = db;
        lu = mtr && (wr != 0) && (wr == rs || wr == rt);
        ev = 0;
        nd = m_drain;
        e.hz = 8'h00; e.ps = 0;
        if (!rn) begin
            m_drain = 0; m_sc = 0; m_fe = 0; nd = 0;
        end else if (!m_drain) begin
            if (db)           begin e.hz = 8'b1010_1001; e.ps = 1; end
            else if (br)      begin e.hz = 8'b0101_0100; e.ps = ib; ev = 1; nd = ib; end
            else if (lu)      begin e.hz = 8'b1001_0000; e.ps = 1; end
            else if (ib)      begin e.hz = 8'b0100_0000; e.ps = 1; end
        end else begin
            e.ps = 1;
            if (db)           e.hz = 8'b0110_1001;
            else if (br)      begin e.hz = 8'b0101_0100; ev = 1; end
            else if (lu)      e.hz = 8'b0101_0000;
            else              e.hz = 8'b0100_0000;
            nd = ib || (br && !db);
        end
        e.rp = m_drain;
        e.sc = 16'(m_sc);
        e.fe = 16'(m_fe);
        exp_q.push_back(e);
        if (rn) begin
            if (e.ps && m_sc < 65535) m_sc++;
            if (ev && m_fe < 65535)   m_fe++;
            m_drain = nd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = hazard;
            n_cmp += 5;
            if (act != e.hz) begin
                n_fail++; $display("FAIL hazard: got %b want %b", act, e.hz);
            end
            if (pc_stall != e.ps) begin
                n_fail++; $display("FAIL pc_stall: got %b want %b", pc_stall, e.ps);
            end
            if (redirect_pending != e.rp) begin
                n_fail++; $display("FAIL redirect_pending: got %b want %b", redirect_pending, e.rp);
            end
            if (stall_cycles != e.sc) begin
                n_fail++; $display("FAIL stall_cycles: got %h want %h", stall_cycles, e.sc);
            end
            if (flush_events != e.fe) begin
                n_fail++; $display("FAIL flush_events: got %h want %h", flush_events, e.fe);
            end
        end
    end

    initial begin
        reset = 0; d_rs = 0; d_rt = 0; e_write_reg = 0;
        e_mem_to_reg = 0; m_branch_taken = 0; i_busy = 0; d_busy = 0;

        // Reset with noisy inputs: everything must stay quiet.
        drive(0, 5, 5, 5, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use on rs, then the load advances.
        drive(1, 5, 3, 5, 1, 0, 0, 0);
        idle(2);
        // Load into r0 is not a hazard.
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        // Load-use on rt.
        drive(1, 1, 9, 9, 1, 0, 0, 0);
        idle(1);

        // Data bus busy for 3 cycles masks a simultaneous load-use.
        for (int i = 0; i < 3; i++) drive(1, 5, 0, 5, 1, 0, 0, 1);
        idle(2);

        // Taken branch during a fetch, fetch outstanding 2 more cycles.
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Second branch while draining, with d_busy interleaved.
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Reset in the middle of a drain, then idle.
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // Randomised traffic with small register numbers to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        // Counter saturation: from reset, 65534 stall cycles reach FFFE,
        // and the next ones must stick at FFFF.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) drive(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)     drive(1, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        @(posedge clk); @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous active-low reset.
REQ-002 clk  input  1  pipeline clock, all state rising-edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state.
REQ-004 d_rs, d_rt  input  5 each  source register addresses of the instruction in decode.
REQ-005 e_write_reg  input  5  destination register of the instruction in execute.
REQ-006 e_mem_to_reg  input  1  instruction in execute is a load.
REQ-007 m_branch_taken  input  1  branch in memory stage resolved taken (branch and zero).
REQ-008 i_busy  input  1  instruction bus fetch outstanding this cycle.
REQ-009 d_busy  input  1  data bus access by the memory stage outstanding this cycle.
REQ-010 hazard  output  hazard_data_t  per-stage flush/stall; fetch→F/D, decode→D/E, execute→E/M, memory→M/W register.
REQ-011 pc_stall  output  1  hold the PC.
REQ-012 redirect_pending  output  1  a taken-branch redirect awaits completion of a wrong-path fetch.
REQ-013 stall_cycles  output  16  saturating count of cycles with pc_stall high.
REQ-014 flush_events  output  16  saturating count of taken-branch flushes.

Function
REQ-015 Load-use hazard SHALL be: e_mem_to_reg=1, e_write_reg≠0, and e_write_reg equals d_rs or d_rt.
REQ-016 Conditions SHALL be prioritised: d_busy > m_branch_taken > load-use > i_busy; only the highest active condition drives outputs, all unlisted bits 0.
REQ-017 d_busy SHALL assert pc_stall and fetch/decode/execute.stall, plus memory.flush (bubble into M/W).
REQ-018 m_branch_taken SHALL assert fetch/decode/execute.flush with pc_stall=0 and increment flush_events.
REQ-019 Load-use SHALL assert pc_stall, fetch.stall and decode.flush (one bubble); it clears itself the next cycle once the load advances.
REQ-020 i_busy alone SHALL assert pc_stall and fetch.flush (bubble into F/D).
REQ-021 FSM states SHALL be RUN and DRAIN; reset state RUN.
REQ-022 RUN→DRAIN SHALL occur when m_branch_taken and i_busy are both 1 and d_busy=0; in that cycle pc_stall=1 in addition to REQ-018.
REQ-023 In DRAIN, redirect_pending=1, pc_stall=1 and fetch.flush=1 every cycle, discarding the wrong-path fetch; d_busy still takes precedence per REQ-017, except fetch.flush also stays 1.
REQ-024 DRAIN→RUN SHALL occur on the first cycle with i_busy=0; that cycle still flushes F/D, and redirect_pending falls the following cycle.
REQ-025 A new m_branch_taken while in DRAIN SHALL keep the FSM in DRAIN and SHALL count as a flush event.
REQ-026 Counters SHALL increment by 1 per qualifying cycle and saturate at 16'hFFFF without wrap.
REQ-027 All hazard and pc_stall outputs SHALL be combinational from inputs and FSM state (zero latency); counters and FSM are registered.
REQ-028 No output bit SHALL assert stall and flush on the same stage simultaneously.

Reset
REQ-029 On reset low: FSM=RUN, redirect_pending=0, stall_cycles=0, flush_events=0, asynchronously.
REQ-030 While reset is low, hazard SHALL be all zero and pc_stall=0 regardless of inputs.
REQ-031 Reset asserted during DRAIN SHALL abandon the pending redirect with no further flush after release.

Structure
REQ-032 hazard_data_t and hazard_data_item_t SHALL stay in the shared pipeline package; the FSM state enum (RUN, DRAIN) SHALL be added to that package.
REQ-033 The load-use comparator SHALL be a sub-module named load_use_detect; counters stay inline.

Verification
REQ-034 e_mem_to_reg=1, e_write_reg=5, d_rs=5 → pc_stall=1, fetch.stall=1, decode.flush=1 for exactly one cycle.
REQ-035 e_mem_to_reg=1, e_write_reg=0, d_rs=0 → no stall or flush.
REQ-036 d_busy=1 for 3 cycles with load-use also active → only the d_busy pattern for 3 cycles; stall_cycles increases by 3.
REQ-037 m_branch_taken=1 with i_busy=1 for 2 more cycles → DRAIN entered, redirect_pending=1 for cycles 2-4, F/D flushed through the i_busy-low cycle, flush_events=1.
REQ-038 Force stall_cycles to 16'hFFFE, hold i_busy=1 for 3 cycles → count reads 16'hFFFF and stays there.
REQ-039 Assert reset mid-DRAIN, release → FSM=RUN, counters 0, redirect_pending=0, no flush with idle inputs.
